// File: rtl/div_param.sv
// ---------------------------------------------------------------------------
// div_param -- iterative signed/unsigned integer divider
//
// Performs one non-restoring division step per clock on a WIDTH+1 bit
// partial remainder. An operation takes WIDTH CALC cycles plus one FIX cycle.
// Signed operands are converted to magnitudes when the request is accepted.
// The signs of the results are applied in FIX.
//
// Handshake: start is sampled only while busy=0. The edge that samples it
// is the accept edge, and busy rises at that edge. Exactly WIDTH+1 edges
// later busy falls and done pulses for one cycle. q/r/div_by_zero are
// valid while done=1 and hold their values until the next done pulse.
// start may be asserted in the done cycle to begin the next operation.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   operation request (ignored while busy)
//   is_signed    in   1 = two's-complement divide, 0 = unsigned
//   dividend     in   [WIDTH] numerator
//   divisor      in   [WIDTH] denominator
//   q            out  [WIDTH] quotient (registered)
//   r            out  [WIDTH] remainder (registered)
//   busy         out  operation in flight
//   done         out  one-cycle result strobe
//   div_by_zero  out  divisor of the completed operation was zero
//   state_dbg    out  [2] current FSM state (0=IDLE, 1=CALC, 2=FIX)
// ---------------------------------------------------------------------------
module div_param #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;     // signed partial remainder
    logic [WIDTH-1:0] quo_q;     // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q;     // divisor magnitude
    logic [WIDTH-1:0] dvd_q;     // dividend as supplied, for the zero-divisor result
    logic             neg_q_q;   // quotient must be negated
    logic             neg_r_q;   // remainder must be negated
    logic             dz_q;      // divisor of the operation in flight is zero
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    // Operand conditioning at accept
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;

    always_comb begin
        a_neg   = is_signed & dividend[WIDTH-1];
        b_neg   = is_signed & divisor[WIDTH-1];
        a_mag_d = a_neg ? -dividend : dividend;
        b_mag_d = b_neg ? -divisor  : divisor;
    end

    // One non-restoring step: shift the next dividend bit into the partial
    // remainder. Subtract the divisor if the remainder was non-negative,
    // and add it back if it was negative. The new quotient bit is the
    // inverted sign of the result. Intermediate overflow past WIDTH+1 bits
    // wraps harmlessly because the true result always lies in [-D, D).
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    always_comb begin
        dvs_ext = {1'b0, dvs_q};
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_d   = rem_q[WIDTH] ? (shifted + dvs_ext) : (shifted - dvs_ext);
        quo_d   = {quo_q[WIDTH-2:0], ~rem_d[WIDTH]};
    end

    // Final correction and sign application. The quotient produced by the
    // non-restoring steps is already exact; only the remainder needs the
    // divisor added back when it ended negative.
    logic [WIDTH:0]   rem_fix;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_res_d;
    logic [WIDTH-1:0] r_res_d;

    always_comb begin
        rem_fix = rem_q[WIDTH] ? (rem_q + dvs_ext) : rem_q;
        r_mag   = rem_fix[WIDTH-1:0];
        if (dz_q) begin
            q_res_d = '1;
            r_res_d = dvd_q;
        end else begin
            q_res_d = neg_q_q ? -quo_q : quo_q;
            r_res_d = neg_r_q ? -r_mag : r_mag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_q   <= '0;
                        quo_q   <= a_mag_d;
                        dvs_q   <= b_mag_d;
                        dvd_q   <= dividend;
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        dz_q    <= (divisor == '0);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    q_q     <= q_res_d;
                    r_q     <= r_res_d;
                    dbz_q   <= dz_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q           = q_q;
    assign r           = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_div_param.sv
// ---------------------------------------------------------------------------
// tb_div_param -- directed bench for div_param (WIDTH=32 and WIDTH=8)
// ---------------------------------------------------------------------------
module tb_div_param;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // WIDTH=32 instance
    logic        start32, sgn32;
    logic [31:0] a32, b32;
    logic [31:0] q32, r32;
    logic        busy32, done32, dz32;
    logic [1:0]  st32;

    // WIDTH=8 instance
    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic [7:0]  q8, r8;
    logic        busy8, done8, dz8;
    logic [1:0]  st8;

    div_param #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(reset), .start(start32), .is_signed(sgn32),
        .dividend(a32), .divisor(b32), .q(q32), .r(r32), .busy(busy32),
        .done(done32), .div_by_zero(dz32), .state_dbg(st32)
    );

    div_param #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .dividend(a8), .divisor(b8), .q(q8), .r(r8), .busy(busy8),
        .done(done8), .div_by_zero(dz8), .state_dbg(st8)
    );

    // scoreboard counters
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request; caller is at a negedge. Returns 1 ns after the accept edge.
    task automatic issue(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = 1'b1; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Wait for done, counting edges since the accept edge. Optionally pulses
    // a spurious start (9/3 signed) into the 32-bit DUT at cycle inject_at.
    // Returns sitting at the negedge of the done cycle.
    task automatic wait_done(input bit w8, input int inject_at,
                             output logic [31:0] rq, output logic [31:0] rr,
                             output logic rdz, output int lat,
                             output int busy_cnt, output logic dz0);
        int  cyc;
        bit  seen;
        cyc = 0; seen = 0; lat = -1; busy_cnt = 0;
        rq = '0; rr = '0; rdz = 1'b0;
        @(negedge clk);
        dz0 = w8 ? dz8 : dz32;
        if (w8 ? busy8 : busy32) busy_cnt++;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == inject_at) begin
                start32 = 1'b1; sgn32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
            end else if (cyc == inject_at + 1) begin
                start32 = 1'b0;
            end
            if (w8 ? done8 : done32) begin
                seen = 1;
                lat  = cyc;
                rq   = w8 ? {24'd0, q8} : q32;
                rr   = w8 ? {24'd0, r8} : r32;
                rdz  = w8 ? dz8 : dz32;
            end else if (w8 ? busy8 : busy32) begin
                busy_cnt++;
            end
        end
        start32 = 1'b0;
    endtask

    task automatic run_check(input string name, input bit w8, input bit sgn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic [31:0] er,
                             input logic edz, input int elat);
        logic [31:0] gq, gr;
        logic        gdz, gdz0;
        int          glat, gbusy;
        issue(w8, sgn, a, b);
        wait_done(w8, -10, gq, gr, gdz, glat, gbusy, gdz0);
        chk({name, "_lat"}, glat, elat);
        chk({name, "_busy"}, gbusy, elat);
        chk({name, "_q"}, gq, eq);
        chk({name, "_r"}, gr, er);
        chk({name, "_dz"}, gdz, edz);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
    } vec_t;

    vec_t vt[15];

    initial begin : main
        logic [31:0] gq, gr;
        logic        gdz, gdz0;
        int          glat, gbusy;

        vt[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vt[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vt[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
        vt[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vt[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vt[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vt[6]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vt[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vt[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vt[9]  = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0};
        vt[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
        vt[11] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vt[12] = '{1'b1, 32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1'b1};
        vt[13] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vt[14] = '{1'b1, 32'd7,          32'd7,          32'd1,          32'd0,          1'b0};

        reset = 1'b1;
        start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q",     q32,    32'd0);
        chk("rst_r",     r32,    32'd0);
        chk("rst_busy",  busy32, 1'b0);
        chk("rst_done",  done32, 1'b0);
        chk("rst_dz",    dz32,   1'b0);
        chk("rst_state", st32,   2'd0);
        chk("rst_q8",    q8,     8'd0);

        // First request goes in at the first edge with reset low; the table
        // then runs back-to-back, each start issued in the previous done cycle.
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            run_check($sformatf("v%0d", i), 1'b0, vt[i].sgn, vt[i].a, vt[i].b,
                      vt[i].eq, vt[i].er, vt[i].edz, 33);
        end

        // Outputs hold while idle
        repeat (5) @(negedge clk);
        chk("hold_q",    q32,    32'd1);
        chk("hold_r",    r32,    32'd0);
        chk("hold_busy", busy32, 1'b0);
        chk("hold_done", done32, 1'b0);

        // start while busy is ignored; then back-to-back start in done cycle
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        wait_done(1'b0, 10, gq, gr, gdz, glat, gbusy, gdz0);
        chk("ign_lat", glat, 33);
        chk("ign_q",   gq,   32'd14);
        chk("ign_r",   gr,   32'd2);
        run_check("b2b", 1'b0, 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, 1'b0, 33);

        // div_by_zero holds through the following operation until its FIX edge
        run_check("dz5", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 33);
        issue(1'b0, 1'b0, 32'd9, 32'd3);
        wait_done(1'b0, -10, gq, gr, gdz, glat, gbusy, gdz0);
        chk("dzhold_mid", gdz0, 1'b1);
        chk("dzhold_dz",  gdz,  1'b0);
        chk("dzhold_q",   gq,   32'd3);

        // reset in the middle of an operation
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_q",    q32,    32'd0);
        chk("abort_r",    r32,    32'd0);
        chk("abort_busy", busy32, 1'b0);
        chk("abort_done", done32, 1'b0);
        chk("abort_dz",   dz32,   1'b0);
        chk("abort_st",   st32,   2'd0);
        reset = 1'b0;
        run_check("post_rst", 1'b0, 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, 1'b0, 33);

        // WIDTH=8 instance
        @(negedge clk);
        run_check("w8_u200_3", 1'b1, 1'b0, 32'd200, 32'd3,  32'd66,  32'd2,  1'b0, 9);
        run_check("w8_ovf",    1'b1, 1'b1, 32'h80,  32'hFF, 32'h80,  32'd0,  1'b0, 9);
        run_check("w8_dz",     1'b1, 1'b1, 32'h80,  32'd0,  32'hFF,  32'h80, 1'b1, 9);
        run_check("w8_sneg",   1'b1, 1'b1, 32'hF9,  32'd2,  32'hFD,  32'hFF, 1'b0, 9);
        run_check("w8_u255",   1'b1, 1'b0, 32'hFF,  32'h10, 32'h0F,  32'h0F, 1'b0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
